// File: rtl/conv_window_buffer.sv
// Streaming K x K sliding-window generator with K-1 chained line buffers.
// Optional macro CONV_WINDOW_STRIDE2_EN restricts emission to even-aligned window origins.
module conv_window_buffer #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int K          = 3,
  parameter int D_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [D_WIDTH-1:0]     in_data,
  output logic                   out_valid,
  output logic [D_WIDTH*K*K:0]   window_data,
  output logic                   frame_done
);

  localparam int SIZE = K * K;
  localparam int NL   = K - 1;
  localparam int CW   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic [D_WIDTH-1:0] line_q [NL][IMG_WIDTH];
  logic [D_WIDTH-1:0] line_d [NL][IMG_WIDTH];
  logic [D_WIDTH-1:0] win_q  [K][K];
  logic [D_WIDTH-1:0] win_d  [K][K];

  logic                    out_valid_q, out_valid_d;
  logic                    frame_done_q, frame_done_d;
  logic [D_WIDTH*SIZE-1:0] window_q, window_d;

  logic last_col, last_row, emit;

  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

`ifdef CONV_WINDOW_STRIDE2_EN
  // Origin (row-K+1, col-K+1) is even exactly when the coordinate's LSB matches the LSB of K-1.
  localparam logic K1_PAR = 1'((K - 1) % 2);
  assign emit = (row_q >= ROW_MIN) && (col_q >= COL_MIN) &&
                (row_q[0] == K1_PAR) && (col_q[0] == K1_PAR);
`else
  assign emit = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
`endif

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    line_d       = line_q;
    win_d        = win_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    window_d     = window_q;

    if (in_valid) begin
      for (int l = 0; l < NL; l++) begin
        for (int x = IMG_WIDTH - 1; x > 0; x--) begin
          line_d[l][x] = line_q[l][x-1];
        end
        line_d[l][0] = (l == 0) ? in_data : line_q[(l > 0) ? l - 1 : 0][IMG_WIDTH-1];
      end

      // Buffer L's tail is the pixel L+1 lines above, so window row r reads buffer K-2-r.
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        win_d[r][K-1] = line_q[K-2-r][IMG_WIDTH-1];
      end
      win_d[K-1][K-1] = in_data;

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      out_valid_d  = emit;
      frame_done_d = last_col && last_row;

      if (emit) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) begin
            window_d[D_WIDTH*(r*K+c) +: D_WIDTH] = win_d[r][c];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      window_q     <= '0;
      for (int l = 0; l < NL; l++) begin
        for (int x = 0; x < IMG_WIDTH; x++) begin
          line_q[l][x] <= '0;
        end
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      window_q     <= window_d;
      line_q       <= line_d;
      win_q        <= win_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign frame_done  = frame_done_q;
  assign window_data = {1'b0, window_q};

endmodule

// File: doc/conv_window_buffer.md
# conv_window_buffer

Streaming sliding-window generator that sits directly upstream of the convolutional layer's inner product unit. It accepts one pixel per cycle in raster order, stores the previous K-1 image lines in internal line buffers, and emits every complete K×K window as a packed vector. The vector is sized and ordered to connect straight to the inner product unit's `input_data` port. Only fully-populated windows are emitted; there is no padding.

## Interface
- `IMG_WIDTH`, 8: pixels per image line; must be ≥ K.
- `IMG_HEIGHT`, 8: lines per frame; must be ≥ K.
- `K`, 3: kernel edge; window holds SIZE = K*K elements.
- `D_WIDTH`, 8: bits per pixel.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_data` carries a pixel this cycle.
- `in_data`  in  D_WIDTH: pixel value, unsigned.
- `out_valid`  out  1: `window_data` holds a new window; one-cycle pulse per window.
- `window_data`  out  D_WIDTH*K*K+1: packed window. Element i sits at [D_WIDTH*(i+1)-1 : D_WIDTH*i]. The MSB (bit D_WIDTH*K*K) is always 0.
- `frame_done`  out  1: one-cycle pulse registered with the last pixel of each frame.

## Operation
- **Counters.**
  - `col` runs 0..IMG_WIDTH-1; `row` runs 0..IMG_HEIGHT-1.
  - Both advance only on cycles where `in_valid`=1.
  - `col` wraps to 0 and increments `row`; `row` wraps to 0 after the last pixel of the frame.
- **Line buffers.** K-1 buffers, each IMG_WIDTH deep, chained; line L-1 feeds line L. They shift only on accepted pixels and are implemented as shift registers or as a circular RAM with a shared pointer.
- **Window register.**
  - A K×K register array; on each accepted pixel every row shifts left by one column.
  - The new rightmost column is taken from the oldest line buffer down to `in_data`: rows 0..K-2 come from the buffers (oldest line = row 0), and row K-1 is `in_data`.
- **Element ordering.** i = r*K + c, where r=0 is the top (oldest) line and c=0 is the leftmost (oldest) column. Element 0 is therefore the top-left pixel and element K*K-1 is the pixel just accepted.
- **Emit rule.** A window is emitted when the accepted pixel has `row` ≥ K-1 and `col` ≥ K-1. This gives (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1) windows per frame.
- **Line-boundary windows.** Windows that straddle a line wrap, i.e. `col` < K-1, are never emitted, even though the register holds stale columns.
- **Idle cycles.** `in_valid`=0 holds all state. Gaps anywhere in the stream do not change the output sequence.
- **Output data.** `window_data` is registered and holds its last value between pulses.

## Timing
- **Latency.** `out_valid` and `window_data` appear 1 cycle after the completing pixel is accepted. `frame_done` is aligned with the final window's `out_valid`.
- **Throughput.** One window per cycle during contiguous valid input within the emit region.
- **No backpressure.** The downstream stage must consume `window_data` in the `out_valid` cycle.
- **Reset values.**
  - `out_valid`=0, `frame_done`=0, `window_data`=0.
  - `col`=0, `row`=0.
  - Line buffers and window register are cleared to 0.
- **Reset mid-frame.**
  - Aborts the frame: no further windows from the partial frame.
  - The pixel presented in the reset cycle is discarded.
  - The next accepted pixel is (row 0, col 0).
- **Frame wrap.** The first pixel of frame N+1 starts at row 0. Windows never mix lines from two frames, because emission restarts only at row ≥ K-1.

## Configuration
- `CONV_WINDOW_STRIDE2_EN`
  - **Defined:** a window is emitted only when its top-left corner (`row`-K+1, `col`-K+1) has both coordinates even. The window count becomes ceil((IMG_WIDTH-K+1)/2)*ceil((IMG_HEIGHT-K+1)/2). `frame_done` still pulses with the last pixel of the frame, even if no window is emitted that cycle.
  - **Undefined:** stride 1, every valid window is emitted.

## Test plan
- **Basic window.** K=3, IMG_WIDTH=IMG_HEIGHT=4, D_WIDTH=8, pixels 0..15 contiguous after reset → first `out_valid` 1 cycle after pixel 10. Elements 0..8 = 0,1,2,4,5,6,8,9,10; bit 72 = 0.
- **Full frame.** Same stimulus → exactly 4 windows, with top-left pixels 0,1,4,5 (last = 5,6,7,9,10,11,13,14,15). `frame_done` is coincident with the 4th `out_valid`.
- **Stalls.** Same frame with `in_valid` deasserted for 1-3 random cycles between pixels → identical window sequence; each window arrives 1 cycle after its completing pixel.
- **Reset mid-frame.** Reset after pixel 9, then stream 0..15 → no window from the aborted frame; output identical to the basic-window test.
- **Back-to-back frames.** Two frames, second = pixels 100..115, no gap → 8 windows total. The 5th window's elements are 100,101,102,104,105,106,108,109,110.
- **Stride 2.** With `CONV_WINDOW_STRIDE2_EN`, IMG_WIDTH=IMG_HEIGHT=5, pixels 0..24 → 4 windows, top-left 0,2,10,12. `frame_done` pulses with pixel 24.
